bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter that sits directly upstream of the bus controller. It multiplexes the CPU (master 0) and a secondary master, such as DMA or video fetch (master 1), onto the single bm_* bus. It holds a grant for the whole transaction. It guarantees a cycle with bm_read and bm_write both low between transactions so the controller's state machine returns to idle. Wait and read data are routed back to the masters.

## Interface
- AW, 32, address width
- DW, 32, data width
- clock  in  1  system clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- m0_address  in  AW  master 0 address
- m0_read / m0_write  in  1  master 0 request strobes, held until m0_wait low
- m0_writedata  in  DW  master 0 write data
- m0_be  in  DW/8  master 0 byte enables
- m0_wait  out  1  master 0 stall
- m0_readdata  out  DW  read data to master 0
- m1_address, m1_read, m1_write, m1_writedata, m1_be, m1_wait, m1_readdata: same as m0_* for master 1
- bm_address  out  AW  to controller/slaves
- bm_read / bm_write  out  1  to controller
- bm_writedata  out  DW, bm_be  out  DW/8
- bm_wait  in  1  stall from controller
- bm_readdata  in  DW  muxed slave read data
- grant  out  2  one-hot current owner, 2'b00 when idle

## Operation
- Definitions: reqN = mN_read | mN_write.
- State is registered: IDLE, GRANT0, GRANT1. The bm_* outputs are a combinational mux selected by state:
  - GRANTn: bm_* = mN_*.
  - IDLE: bm_read = bm_write = 0; bm_address, bm_writedata and bm_be = 0.
- IDLE transitions:
  - req0 only → GRANT0.
  - req1 only → GRANT1.
  - Both → winner per priority (see Configuration).
  - Neither → stay in IDLE.
- GRANTn transitions:
  - Stay while reqN = 1.
  - When reqN = 0 (the master has dropped its strobe, so bm strobes are already low this cycle): → GRANTm if reqm = 1 (m is the other master), else IDLE.
  - The other master is never granted while reqN = 1, whatever the length of the stall.
- Wait routing:
  - Granted master: mN_wait = bm_wait.
  - Any other master with reqN = 1: mN_wait = 1.
  - Non-requesting master: mN_wait = 0.
- mN_readdata = bm_readdata for both masters. Only the granted master samples it.
- last register: records the most recently granted master; updated on every entry to GRANTn.

## Timing
- Reset (async): state IDLE, last = 1 (so master 0 wins the first round-robin tie), grant = 0, bm_read = bm_write = 0, bm_address = 0, bm_writedata = 0, bm_be = 0, m0_wait = m1_wait = 0 (while strobes are low).
- Arbitration latency: request first seen in IDLE at edge n → bm strobe visible in cycle n+1. mN_wait = 1 during the IDLE cycle.
- Back-to-back handover: the dropping master's low cycle is the dead cycle; the new master drives bm in the next cycle. No extra idle cycle.
- A master may not reassert its strobe in the same cycle it drops it. This is a master rule; the arbiter does not check it.
- Reset mid-transaction: bm strobes drop immediately (asynchronously); the controller aborts through its no-request path.
- Simultaneous drop of reqN and rise of reqm while in GRANTn → GRANTm next cycle.

## Configuration
- ARB_ROUNDROBIN_EN defined: on an IDLE tie, grant the master other than last. After GRANT0 completes with req1 pending, GRANT1 follows; the reverse holds too.
- ARB_ROUNDROBIN_EN undefined: fixed priority. An IDLE tie always grants master 0; last is still maintained but ignored. The handover rule in GRANTn is unchanged.

## Test plan
- Reset: hold reset_n = 0 while m0_read = 1 → bm_read = 0, grant = 0, bm_address = 0; release → grant = 2'b01 one cycle later, bm_address = m0_address.
- Single master read: m0_read with address 32'h00800010; controller stalls 3 cycles → m0_wait mirrors bm_wait, m0_readdata = bm_readdata, m1_wait = 0.
- Tie from idle with ARB_ROUNDROBIN_EN: both masters request from reset → order GRANT0, GRANT1, GRANT0, each transaction separated by exactly one cycle with bm_read = 0.
- Tie without ARB_ROUNDROBIN_EN: m0 issues 3 back-to-back reads (strobe low 1 cycle between each) while m1 requests continuously → m1 is served only after a cycle in which req0 = 0 coincides with the GRANT0 drop; m1_wait = 1 throughout.
- Long stall: bm_wait held high 20 cycles during a GRANT1 write with req0 = 1 → grant stays 2'b10, bm_write stays 1, m0_wait = 1 for all 20 cycles.
- Reset mid-op: assert reset_n low during GRANT0 with bm_wait = 1 → bm_read falls in the same cycle, grant = 0, and state is IDLE on release.

Source files
------------

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_if
// Description : Master-side bus bundle used by the two-master arbiter:
//               address/strobes/write data/byte enables one way, stall and
//               read data the other.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [AW-1:0]   address;
  logic            read;
  logic            write;
  logic [DW-1:0]   writedata;
  logic [DW/8-1:0] be;
  logic            waitreq;
  logic [DW-1:0]   readdata;

  // Requester side: drives the request, receives stall and read data
  modport master (
    output address, read, write, writedata, be,
    input  waitreq, readdata
  );

  // Responder side: receives the request, drives stall and read data
  modport slave (
    input  address, read, write, writedata, be,
    output waitreq, readdata
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Two-master arbiter in front of the bus controller. Holds the
//               grant for a whole transaction; the dropping master's low
//               strobe cycle is the dead cycle that returns the controller
//               to idle before the next owner drives the bus.
// Config      : ARB_ROUNDROBIN_EN - idle ties go to the master that was not
//               granted last; when undefined, idle ties go to master 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  wire logic     clock,
  input  wire logic     reset_n,
  bus_arbiter_if.slave  m0,
  bus_arbiter_if.slave  m1,
  bus_arbiter_if.master bm,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   last_q;      // 0: master 0 granted most recently, 1: master 1
  logic   last_d;
  logic   req0;
  logic   req1;
  logic   tie_pick1;   // winner of an idle tie is master 1

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

`ifdef ARB_ROUNDROBIN_EN
  assign tie_pick1 = ~last_q;
`else
  assign tie_pick1 = 1'b0;
`endif

  // Owner and last-granted registers; async reset drops the bus immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next owner: hold while the owner requests, hand over on its low cycle
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = tie_pick1 ? GRANT1 : GRANT0;
        else if (req0)    state_d = GRANT0;
        else if (req1)    state_d = GRANT1;
        else              state_d = IDLE;
      end
      GRANT0: begin
        if (!req0) state_d = req1 ? GRANT1 : IDLE;
      end
      GRANT1: begin
        if (!req1) state_d = req0 ? GRANT0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      if (state_d == GRANT0) last_d = 1'b0;
      if (state_d == GRANT1) last_d = 1'b1;
    end
  end

  // Bus mux, grant vector and stall routing selected by the current owner
  always_comb begin
    bm.address   = {AW{1'b0}};
    bm.read      = 1'b0;
    bm.write     = 1'b0;
    bm.writedata = {DW{1'b0}};
    bm.be        = {(DW/8){1'b0}};
    grant        = 2'b00;
    m0.waitreq   = req0;
    m1.waitreq   = req1;
    case (state_q)
      GRANT0: begin
        bm.address   = m0.address;
        bm.read      = m0.read;
        bm.write     = m0.write;
        bm.writedata = m0.writedata;
        bm.be        = m0.be;
        grant        = 2'b01;
        m0.waitreq   = bm.waitreq;
      end
      GRANT1: begin
        bm.address   = m1.address;
        bm.read      = m1.read;
        bm.write     = m1.write;
        bm.writedata = m1.writedata;
        bm.be        = m1.be;
        grant        = 2'b10;
        m1.waitreq   = bm.waitreq;
      end
      default: ;
    endcase
  end

  assign m0.readdata = bm.readdata;
  assign m1.readdata = bm.readdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Randomized scoreboard bench for bus_arbiter. Legal masters and
//               a random controller are driven each cycle; an ownership model
//               predicts the bus, grant and stall outputs, and a monitor pops
//               and compares them mid-cycle. Directed reset cases included.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_ROUNDROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] grant;

  bus_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  bus_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
  bus_arbiter_if #(.AW(AW), .DW(DW)) bm_if ();

  bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .m0      (m0_if),
    .m1      (m1_if),
    .bm      (bm_if),
    .grant   (grant)
  );

  always #5 clock = ~clock;

  // Master and controller stimulus
  logic [AW-1:0]   ma  [2];
  logic            mr  [2];
  logic            mw  [2];
  logic [DW-1:0]   mwd [2];
  logic [DW/8-1:0] mbe [2];
  logic            bwait;
  logic [DW-1:0]   brd;

  assign m0_if.address   = ma[0];
  assign m0_if.read      = mr[0];
  assign m0_if.write     = mw[0];
  assign m0_if.writedata = mwd[0];
  assign m0_if.be        = mbe[0];
  assign m1_if.address   = ma[1];
  assign m1_if.read      = mr[1];
  assign m1_if.write     = mw[1];
  assign m1_if.writedata = mwd[1];
  assign m1_if.be        = mbe[1];
  assign bm_if.waitreq   = bwait;
  assign bm_if.readdata  = brd;

  typedef struct {
    logic [1:0]      grant;
    logic            rd;
    logic            wr;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] be;
    logic            w0;
    logic            w1;
    logic [DW-1:0]   rdata;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: owner -1 = nobody, otherwise master index
  int   own  = -1;
  int   last = 1;
  logic prev_w [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit req_of(input int n);
    return mr[n] | mw[n];
  endfunction

  task automatic model_reset();
    own  = -1;
    last = 1;
  endtask

  // Ownership rules evaluated on the request levels present at the edge
  task automatic model_edge();
    int prev;
    bit r [2];
    r[0] = req_of(0);
    r[1] = req_of(1);
    prev = own;
    if (prev >= 0)
      own = r[prev] ? prev : (r[1-prev] ? 1 - prev : -1);
    else if (r[0] && r[1])
      own = RR ? 1 - last : 0;
    else if (r[0])
      own = 0;
    else if (r[1])
      own = 1;
    else
      own = -1;
    if (own >= 0 && own != prev) last = own;
  endtask

  task automatic push_expected();
    exp_t e;
    e.grant = (own < 0) ? 2'b00 : 2'(1 << own);
    e.rd    = (own < 0) ? 1'b0 : mr[own];
    e.wr    = (own < 0) ? 1'b0 : mw[own];
    e.addr  = (own < 0) ? '0 : ma[own];
    e.wdata = (own < 0) ? '0 : mwd[own];
    e.be    = (own < 0) ? '0 : mbe[own];
    e.w0    = (own == 0) ? bwait : req_of(0);
    e.w1    = (own == 1) ? bwait : req_of(1);
    e.rdata = brd;
    prev_w[0] = e.w0;
    prev_w[1] = e.w1;
    sb.push_back(e);
  endtask

  // One clock of legal master behaviour plus a random controller
  task automatic step(input int wait_pct, input int req_pct);
    @(posedge clock);
    model_edge();
    #1;
    for (int n = 0; n < 2; n++) begin
      if (req_of(n)) begin
        if (!prev_w[n]) begin
          mr[n] = 1'b0;
          mw[n] = 1'b0;
        end
      end else if ($urandom_range(0, 99) < req_pct) begin
        mr[n]  = $urandom_range(0, 1) == 1;
        mw[n]  = !mr[n];
        ma[n]  = $urandom;
        mwd[n] = $urandom;
        mbe[n] = 4'($urandom);
      end else begin
        ma[n]  = $urandom;
        mwd[n] = $urandom;
        mbe[n] = 4'($urandom);
      end
    end
    bwait = $urandom_range(0, 99) < wait_pct;
    brd   = $urandom;
    push_expected();
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued prediction
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("grant",        64'(grant),              64'(e.grant));
      chk("bm_read",      64'(bm_if.read),         64'(e.rd));
      chk("bm_write",     64'(bm_if.write),        64'(e.wr));
      chk("bm_address",   64'(bm_if.address),      64'(e.addr));
      chk("bm_writedata", 64'(bm_if.writedata),    64'(e.wdata));
      chk("bm_be",        64'(bm_if.be),           64'(e.be));
      chk("m0_wait",      64'(m0_if.waitreq),      64'(e.w0));
      chk("m1_wait",      64'(m1_if.waitreq),      64'(e.w1));
      chk("m0_readdata",  64'(m0_if.readdata),     64'(e.rdata));
      chk("m1_readdata",  64'(m1_if.readdata),     64'(e.rdata));
    end
  end

  task automatic clear_masters();
    for (int n = 0; n < 2; n++) begin
      mr[n] = 1'b0; mw[n] = 1'b0; ma[n] = '0; mwd[n] = '0; mbe[n] = '0;
      prev_w[n] = 1'b0;
    end
    bwait = 1'b0;
    brd   = '0;
  endtask

  initial begin
    bit found;
    clear_masters();

    // Reset held with master 0 already reading: bus stays quiet
    reset_n = 1'b0;
    mr[0]   = 1'b1;
    ma[0]   = 32'h0080_0010;
    mbe[0]  = 4'hF;
    bwait   = 1'b1;
    prev_w[0] = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_bm_read", 64'(bm_if.read),    64'd0);
    chk("rst_grant",   64'(grant),         64'd0);
    chk("rst_bm_addr", 64'(bm_if.address), 64'd0);
    chk("rst_m1_wait", 64'(m1_if.waitreq), 64'd0);
    reset_n = 1'b1;
    model_reset();

    // First cycle after release grants master 0; then a 3-cycle stall
    step(100, 0);
    step(100, 0);
    step(100, 0);
    step(0, 0);
    repeat (10) step(0, 0);

    // Random mixes of stall density and request rate
    repeat (300) step(30, 50);
    repeat (300) step(60, 100);
    repeat (200) step(10, 100);

    // Long stall: controller holds wait for 20 cycles
    repeat (20) step(100, 100);
    repeat (200) step(40, 70);

    // Reset in mid-transaction while master 0 owns the bus and is stalled
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(70, 80);
      if (own == 0 && req_of(0) && prev_w[0]) found = 1'b1;
    end
    chk("midop_reached", 64'(found), 64'd1);
    @(negedge clock);
    #1;
    bwait   = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("midop_bm_read",  64'(bm_if.read | bm_if.write), 64'd0);
    chk("midop_grant",    64'(grant),                    64'd0);
    chk("midop_bm_addr",  64'(bm_if.address),            64'd0);
    @(posedge clock);
    #1;
    clear_masters();
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    repeat (3) step(0, 0);
    repeat (300) step(35, 60);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
